// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: sequences EX load/store ops onto a single-outstanding req/gnt/rvalid data bus
module riscv_lsu_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_req_i,
  output logic                  lsu_ready_o,
  input  logic                  lsu_op_i,
  input  logic [2:0]            lsu_dtype_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_done_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_misaligned_o,
  output logic                  lsu_bus_err_o,
  output logic                  lsu_busy_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_e state, state_nx;
  logic op_q;
  logic [2:0] dtype_q;
  logic [1:0] off_q;
  logic [15:0] cnt;
  logic accept, misal, timeout, gnt_ev, rv_ev, leave;
  logic [31:0] shifted, ext;
  assign lsu_ready_o = state == IDLE;
  assign lsu_busy_o  = state != IDLE;
  assign accept  = lsu_req_i & lsu_ready_o;
  assign misal   = lsu_dtype_i[1] ? |lsu_addr_i[1:0] : lsu_dtype_i[0] & lsu_addr_i[0];
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign gnt_ev  = (state == REQ) && data_gnt_i;
  assign rv_ev   = (state == RESP) && data_rvalid_i;
  assign leave   = lsu_busy_o && (state_nx == IDLE);
  // dtype[1:0]: 00 byte, 01 half, 1x word; dtype[2] selects zero-extension
  assign shifted = data_rdata_i >> {off_q, 3'b000};
  assign ext = dtype_q[1] ? shifted :
               dtype_q[0] ? {{16{~dtype_q[2] & shifted[15]}}, shifted[15:0]} :
                            {{24{~dtype_q[2] & shifted[7]}}, shifted[7:0]};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (accept && !misal) ? REQ : IDLE;
      REQ:     state_nx = gnt_ev ? RESP : timeout ? IDLE : REQ;
      RESP:    state_nx = (rv_ev || timeout) ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      op_q             <= 1'b0;
      dtype_q          <= '0;
      off_q            <= '0;
      lsu_done_o       <= 1'b0;
      lsu_rdata_o      <= '0;
      lsu_misaligned_o <= 1'b0;
      lsu_bus_err_o    <= 1'b0;
      data_req_o       <= 1'b0;
      data_we_o        <= 1'b0;
      data_be_o        <= '0;
      data_addr_o      <= '0;
      data_wdata_o     <= '0;
    end else begin
      state            <= state_nx;
      cnt              <= (state_nx != state) ? '0 : cnt + 16'd1;
      lsu_done_o       <= (accept & misal) | leave;
      lsu_misaligned_o <= accept & misal;
      lsu_bus_err_o    <= leave & ~(rv_ev & ~data_err_i);
      lsu_rdata_o      <= (rv_ev && !data_err_i && !op_q) ? ext : '0;
      data_req_o       <= state_nx == REQ;
      if (accept) begin
        op_q         <= lsu_op_i;
        dtype_q      <= lsu_dtype_i;
        off_q        <= lsu_addr_i[1:0];
        data_we_o    <= lsu_op_i;
        data_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        data_be_o    <= lsu_dtype_i[1] ? 4'b1111 :
                        lsu_dtype_i[0] ? 4'b0011 << lsu_addr_i[1:0] : 4'b0001 << lsu_addr_i[1:0];
        data_wdata_o <= lsu_dtype_i[1] ? lsu_wdata_i :
                        lsu_dtype_i[0] ? {2{lsu_wdata_i[15:0]}} : {4{lsu_wdata_i[7:0]}};
      end
    end
  end
endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// tb_riscv_lsu_ctrl: randomized scoreboard bench for riscv_lsu_ctrl with a bus responder
module tb_riscv_lsu_ctrl;
  localparam int T = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic lsu_req_i = 0, lsu_op_i = 0, lsu_ready_o, lsu_done_o, lsu_misaligned_o, lsu_bus_err_o, lsu_busy_o;
  logic [2:0] lsu_dtype_i = 0;
  logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0, lsu_rdata_o;
  logic data_req_o, data_gnt_i = 0, data_we_o, data_rvalid_i = 0, data_err_i = 0;
  logic [3:0] data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = 0;

  riscv_lsu_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .lsu_req_i(lsu_req_i), .lsu_ready_o(lsu_ready_o), .lsu_op_i(lsu_op_i),
    .lsu_dtype_i(lsu_dtype_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o), .lsu_misaligned_o(lsu_misaligned_o),
    .lsu_bus_err_o(lsu_bus_err_o), .lsu_busy_o(lsu_busy_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .data_err_i(data_err_i));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic [31:0] rdata; logic mis; logic err;} done_t;
  typedef struct {int drop; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} bus_t;
  done_t dq[$];
  bus_t bq[$];
  int errors = 0, checks = 0;
  logic prev_req = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // completion monitor
  always @(negedge clk) begin
    done_t e;
    if (lsu_done_o) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = dq.pop_front();
        chk("done_cycle", 96'(cyc), 96'(e.c));
        chk("rdata", 96'(lsu_rdata_o), 96'(e.rdata));
        chk("misaligned", 96'(lsu_misaligned_o), 96'(e.mis));
        chk("bus_err", 96'(lsu_bus_err_o), 96'(e.err));
      end
    end
  end

  // bus monitor: fields must hold while req is up; req must drop on the expected cycle
  always @(negedge clk) begin
    if (data_req_o) begin
      if (bq.size() == 0) chk("unexpected_req", 1, 0);
      else chk("bus_fields", {data_we_o, data_be_o, data_addr_o, data_wdata_o},
               {bq[0].we, bq[0].be, bq[0].addr, bq[0].wdata});
    end
    if (prev_req && !data_req_o && bq.size() > 0) begin
      chk("req_drop_cycle", 96'(cyc), 96'(bq[0].drop));
      void'(bq.pop_front());
    end
    prev_req = data_req_o;
  end

  // Reference model plus driver; called at a negedge with the DUT idle.
  task automatic issue(input bit op, input logic [2:0] dt, input logic [31:0] addr, input logic [31:0] wd,
                       input int gd, input int rd, input logic [31:0] raw, input bit err, input int gap);
    int n, off, k, tg, tr, done_c, req_end;
    bit mis, e_err, breq, bresp;
    logic [31:0] v, mask;
    done_t d;
    bus_t b;
    n = dt[1] ? 4 : (dt[0] ? 2 : 1);
    off = int'(addr % 4);
    mis = (addr % n) != 0;
    k = cyc;
    tg = -1; tr = -1; e_err = 0; v = 0;
    if (mis) done_c = k + 1;
    else if (gd >= T) begin done_c = k + 1 + T; e_err = 1; end
    else begin
      tg = k + 1 + gd;
      if (rd >= T) begin done_c = tg + 1 + T; e_err = 1; end
      else begin
        tr = tg + 1 + rd; done_c = tr + 1; e_err = err;
        if (!err && !op) begin
          mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 1;
          v = (raw >> (8 * off)) & mask;
          if (n < 4 && !dt[2] && v[8*n-1]) v = v | ~mask;
        end
      end
    end
    req_end = (gd < T) ? k + 1 + gd : done_c - 1;
    d.c = done_c; d.rdata = v; d.mis = mis; d.err = e_err;
    dq.push_back(d);
    if (!mis) begin
      b.drop = (gd < T) ? tg + 1 : done_c;
      b.we = op; b.addr = addr & ~32'h3;
      b.be = 4'(((1 << n) - 1) << off);
      b.wdata = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
      bq.push_back(b);
    end
    for (int c = k; c < done_c + gap; c++) begin
      breq  = !mis && c >= k + 1 && c <= req_end;
      bresp = !mis && gd < T && c >= k + 2 + gd && c <= done_c - 1;
      lsu_req_i   = (c == k) || (c > k && c < done_c && $urandom_range(0, 3) == 0);
      lsu_op_i    = (c == k) ? op : 1'($urandom());
      lsu_dtype_i = (c == k) ? dt : 3'($urandom());
      lsu_addr_i  = (c == k) ? addr : $urandom();
      lsu_wdata_i = (c == k) ? wd : $urandom();
      data_gnt_i  = breq ? (c == tg) : ((c == done_c && e_err) || $urandom_range(0, 3) == 0);
      data_rvalid_i = bresp ? (c == tr) : ((c == done_c && e_err) || $urandom_range(0, 3) == 0);
      data_rdata_i  = (c == tr) ? raw : $urandom();
      data_err_i    = (c == tr) ? err : 1'($urandom());
      @(negedge clk);
    end
    lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
  endtask

  task automatic reset_mid_resp();
    bus_t b;
    b.drop = cyc + 2; b.we = 0; b.be = 4'hF; b.addr = 32'h5000; b.wdata = 32'h0;
    bq.push_back(b);
    lsu_req_i = 1; lsu_op_i = 0; lsu_dtype_i = 3'b010; lsu_addr_i = 32'h5000; lsu_wdata_i = 0;
    @(negedge clk);
    lsu_req_i = 0; data_gnt_i = 1;
    @(negedge clk);
    data_gnt_i = 0; rst = 1;
    @(negedge clk);
    rst = 0; data_rvalid_i = 1; data_rdata_i = 32'hDEAD_BEEF;
    chk("rst_ready", 96'(lsu_ready_o), 1);
    chk("rst_req_busy_done", {data_req_o, lsu_busy_o, lsu_done_o}, 0);
    @(negedge clk);
    @(negedge clk);
    data_rvalid_i = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_lsu", {lsu_ready_o, lsu_done_o, lsu_rdata_o, lsu_misaligned_o, lsu_bus_err_o, lsu_busy_o},
        {1'b1, 36'h0});
    chk("reset_bus", {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o}, 0);
    rst = 0;
    @(negedge clk);
    issue(0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF00, 0, 1);
    issue(1, 3'b001, 32'h2002, 32'h1234_ABCD, 3, 0, 32'h0, 0, 1);
    issue(0, 3'b010, 32'h3001, 32'h0, 0, 0, 32'h0, 0, 0);
    issue(0, 3'b010, 32'h3004, 32'h0, 0, 0, 32'hCAFE_F00D, 0, 0);
    issue(0, 3'b101, 32'h4002, 32'h0, 0, 1, 32'h8765_4321, 1, 1);
    issue(0, 3'b010, 32'h6000, 32'h0, 99, 0, 32'h0, 0, 3);
    issue(0, 3'b001, 32'h7002, 32'h0, 1, 99, 32'h0, 0, 2);
    reset_mid_resp();
    for (int i = 0; i < 300; i++) begin
      logic [2:0] dt;
      dt = 3'($urandom_range(0, 7));
      if (dt == 3'b110) dt = 3'b010;
      issue(1'($urandom()), dt, $urandom(), $urandom(), $urandom_range(0, 5), $urandom_range(0, 5),
            $urandom(), $urandom_range(0, 7) == 0, $urandom_range(0, 2));
    end
    repeat (10) @(negedge clk);
    chk("done_queue_empty", 96'(dq.size()), 0);
    chk("bus_queue_empty", 96'(bq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
